// File: rtl/riscv_main_ctrl_fsm_if.sv
// rtl/riscv_main_ctrl_fsm_if.sv - control/datapath bundle between main control FSM and the datapath/memory side
interface riscv_main_ctrl_fsm_if;
  logic [31:0] instr_rdata;
  logic        mem_ready;
  logic        zero;
  logic        mem_req;
  logic        adr_src;
  logic        mem_write;
  logic        ir_write;
  logic        pc_en;
  logic        reg_write;
  logic [1:0]  result_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [9:0]  func;
  logic        illegal;

  modport master (
    input  instr_rdata, mem_ready, zero,
    output mem_req, adr_src, mem_write, ir_write, pc_en, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, func, illegal
  );

  modport slave (
    output instr_rdata, mem_ready, zero,
    input  mem_req, adr_src, mem_write, ir_write, pc_en, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, func, illegal
  );
endinterface

// File: rtl/riscv_main_ctrl_fsm.sv
// rtl/riscv_main_ctrl_fsm.sv - multicycle RISC-V main control FSM (R-type, LW, SW, BEQ)
// Optional trap state for unsupported opcodes: define RISCV_CTRL_ILLEGAL_TRAP_EN.
module riscv_main_ctrl_fsm (
  input  logic                  clk,
  input  logic                  rst,
  riscv_main_ctrl_fsm_if.master bus
);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECR, S_ALUWB, S_BEQ, S_TRAP
  } state_t;
`else
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECR, S_ALUWB, S_BEQ
  } state_t;
`endif

  state_t     state, state_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  logic       mem_req_c, adr_src_c, mem_write_c, ir_write_c, pc_en_c, reg_write_c, illegal_c;
  logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, alu_op_c;
  logic [9:0] func_c;

  // Operand/destination fields of the instruction word are consumed by the datapath, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.instr_rdata[24:15], bus.instr_rdata[11:7]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_FETCH;
      opcode <= '0;
      funct3 <= '0;
      funct7 <= '0;
    end else begin
      state <= state_n;
      if (ir_write_c) begin
        opcode <= bus.instr_rdata[6:0];
        funct3 <= bus.instr_rdata[14:12];
        funct7 <= bus.instr_rdata[31:25];
      end
    end
  end

  always_comb begin
    state_n      = state;
    mem_req_c    = 1'b0;
    adr_src_c    = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    pc_en_c      = 1'b0;
    reg_write_c  = 1'b0;
    illegal_c    = 1'b0;
    result_src_c = 2'b00;
    alu_src_a_c  = 2'b00;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_en_c    = 1'b1;
          state_n    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_R:         state_n = S_EXECR;
          OP_BEQ:       state_n = S_BEQ;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
          default:      state_n = S_TRAP;
`else
          default:      state_n = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        state_n     = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (bus.mem_ready) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
        state_n      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        adr_src_c   = 1'b1;
        mem_write_c = 1'b1;
        if (bus.mem_ready) state_n = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = 2'b10;
        state_n     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_n     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = 2'b01;
        pc_en_c     = bus.zero;
        state_n     = S_FETCH;
      end
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal_c = 1'b1;
      end
`endif
      default: state_n = S_FETCH;
    endcase

    // Strobes are gated by rst directly so nothing fires in the cycle reset rises.
    if (rst) begin
      mem_req_c   = 1'b0;
      mem_write_c = 1'b0;
      ir_write_c  = 1'b0;
      pc_en_c     = 1'b0;
      reg_write_c = 1'b0;
    end
  end

  always_comb begin
    func_c = 10'b0000000_010;
    case (alu_op_c)
      2'b10:   func_c = {funct7, funct3};
      2'b01:   func_c = 10'b0000001_000;
      default: func_c = 10'b0000000_010;
    endcase
  end

  assign bus.mem_req    = mem_req_c;
  assign bus.adr_src    = adr_src_c;
  assign bus.mem_write  = mem_write_c;
  assign bus.ir_write   = ir_write_c;
  assign bus.pc_en      = pc_en_c;
  assign bus.reg_write  = reg_write_c;
  assign bus.result_src = result_src_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.alu_op     = alu_op_c;
  assign bus.func       = func_c;
  assign bus.illegal    = illegal_c;
endmodule

// File: tb/tb_riscv_main_ctrl_fsm.sv
// tb/tb_riscv_main_ctrl_fsm.sv - randomized self-checking bench for riscv_main_ctrl_fsm
module tb_riscv_main_ctrl_fsm;
  typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                    P_EXECR, P_ALUWB, P_BEQ, P_TRAP, P_RESET} phase_e;
  typedef enum int {K_R, K_LW, K_SW, K_BEQ, K_ILL} kind_e;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       pc_en;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [9:0] func;
    logic       illegal;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] ir_m = '0;
  out_t obs;

  riscv_main_ctrl_fsm_if bus ();
  riscv_main_ctrl_fsm dut (.clk(clk), .rst(rst), .bus(bus.master));

  always #5 clk = ~clk;

  assign obs = {bus.mem_req, bus.adr_src, bus.mem_write, bus.ir_write, bus.pc_en,
                bus.reg_write, bus.result_src, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.func, bus.illegal};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, want);
    end
  endtask

  // Expected control word for one cycle of a given instruction phase.
  function automatic out_t exp_out(phase_e p, logic rdy, logic z, logic [31:0] irm);
    out_t o;
    o = '0;
    case (p)
      P_FETCH:    begin o.mem_req = 1; o.alu_src_b = 2; o.result_src = 2; o.ir_write = rdy; o.pc_en = rdy; end
      P_RESET:    begin o.alu_src_b = 2; o.result_src = 2; end
      P_DECODE:   begin o.alu_src_a = 1; o.alu_src_b = 1; end
      P_MEMADR:   begin o.alu_src_a = 2; o.alu_src_b = 1; end
      P_MEMREAD:  begin o.mem_req = 1; o.adr_src = 1; end
      P_MEMWB:    begin o.result_src = 1; o.reg_write = 1; end
      P_MEMWRITE: begin o.mem_req = 1; o.adr_src = 1; o.mem_write = 1; end
      P_EXECR:    begin o.alu_src_a = 2; o.alu_op = 2; end
      P_ALUWB:    begin o.reg_write = 1; end
      P_BEQ:      begin o.alu_src_a = 2; o.alu_op = 1; o.pc_en = z; end
      P_TRAP:     begin o.illegal = 1; end
      default:    o = '0;
    endcase
    if (o.alu_op == 2) o.func = {irm[31:25], irm[14:12]};
    else if (o.alu_op == 1) o.func = 10'b0000001_000;
    else o.func = 10'b0000000_010;
    return o;
  endfunction

  task automatic cyc(input phase_e p, input logic rdy, input logic z, input logic [31:0] d, input string tag);
    out_t e;
    bus.mem_ready   = rdy;
    bus.zero        = z;
    bus.instr_rdata = d;
    @(negedge clk);
    e = exp_out(p, rdy, z, ir_m);
    chk(tag, {7'd0, obs}, {7'd0, e});
    if (p == P_FETCH && rdy) ir_m = d;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    @(negedge clk);
    chk(tag, {7'd0, obs}, {7'd0, exp_out(P_RESET, 1'b0, 1'b0, ir_m)});
    @(posedge clk);
    #1;
    rst = 1'b0;
    ir_m = '0;
  endtask

  task automatic run_instr(input kind_e k, input logic [31:0] instr, input int fw, input int mw,
                           input logic z, input string nm);
    for (int i = 0; i < fw; i++) cyc(P_FETCH, 1'b0, 1'($urandom), $urandom, {nm, "_fetchwait"});
    cyc(P_FETCH, 1'b1, 1'($urandom), instr, {nm, "_fetch"});
    cyc(P_DECODE, 1'($urandom), 1'($urandom), $urandom, {nm, "_decode"});
    case (k)
      K_R: begin
        cyc(P_EXECR, 1'($urandom), 1'($urandom), $urandom, {nm, "_execr"});
        cyc(P_ALUWB, 1'($urandom), 1'($urandom), $urandom, {nm, "_aluwb"});
      end
      K_LW: begin
        cyc(P_MEMADR, 1'($urandom), 1'($urandom), $urandom, {nm, "_memadr"});
        for (int i = 0; i < mw; i++) cyc(P_MEMREAD, 1'b0, 1'($urandom), $urandom, {nm, "_rdwait"});
        cyc(P_MEMREAD, 1'b1, 1'($urandom), $urandom, {nm, "_memread"});
        cyc(P_MEMWB, 1'($urandom), 1'($urandom), $urandom, {nm, "_memwb"});
      end
      K_SW: begin
        cyc(P_MEMADR, 1'($urandom), 1'($urandom), $urandom, {nm, "_memadr"});
        for (int i = 0; i < mw; i++) cyc(P_MEMWRITE, 1'b0, 1'($urandom), $urandom, {nm, "_wrwait"});
        cyc(P_MEMWRITE, 1'b1, 1'($urandom), $urandom, {nm, "_memwrite"});
      end
      K_BEQ: cyc(P_BEQ, 1'($urandom), z, $urandom, {nm, "_beq"});
      default: begin
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) cyc(P_TRAP, 1'($urandom), 1'($urandom), $urandom, {nm, "_trap"});
        reset_pulse({nm, "_trapreset"});
`endif
      end
    endcase
  endtask

  function automatic logic [31:0] gen(kind_e k);
    logic [31:0] w;
    logic [6:0]  op;
    w = $urandom;
    case (k)
      K_R: begin
        w[6:0] = 7'b0110011;
        case ($urandom_range(0, 2))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          default: ;
        endcase
      end
      K_LW:  w[6:0] = 7'b0000011;
      K_SW:  w[6:0] = 7'b0100011;
      K_BEQ: w[6:0] = 7'b1100011;
      default: begin
        op = 7'($urandom);
        while (op == 7'b0110011 || op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100011)
          op = 7'($urandom);
        w[6:0] = op;
      end
    endcase
    return w;
  endfunction

  initial begin
    kind_e k;
    bus.mem_ready   = 1'b0;
    bus.zero        = 1'b0;
    bus.instr_rdata = '0;
    @(negedge clk);
    chk("reset_state", {7'd0, obs}, {7'd0, exp_out(P_RESET, 1'b0, 1'b0, ir_m)});
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("reset_ready_ignored", {7'd0, obs}, {7'd0, exp_out(P_RESET, 1'b1, 1'b0, ir_m)});
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr(K_R,   32'h002081B3, 0, 0, 1'b0, "add");
    run_instr(K_R,   32'h402081B3, 1, 0, 1'b0, "sub");
    run_instr(K_LW,  32'h0000A183, 0, 0, 1'b0, "lw");
    run_instr(K_SW,  32'h0030A023, 0, 3, 1'b0, "sw_wait3");
    run_instr(K_BEQ, 32'h00208463, 0, 0, 1'b1, "beq_taken");
    run_instr(K_BEQ, 32'h00208463, 2, 0, 1'b0, "beq_not");

    // Reset rising mid-cycle while in MEMWB: write strobe must drop immediately.
    cyc(P_FETCH, 1'b1, 1'b0, 32'h0000A183, "rst_lw_fetch");
    cyc(P_DECODE, 1'b0, 1'b0, $urandom, "rst_lw_decode");
    cyc(P_MEMADR, 1'b0, 1'b0, $urandom, "rst_lw_memadr");
    cyc(P_MEMREAD, 1'b1, 1'b0, $urandom, "rst_lw_memread");
    bus.mem_ready = 1'b1;
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_memwb", {7'd0, obs}, {7'd0, exp_out(P_RESET, 1'b1, 1'b0, ir_m)});
    chk("rst_in_memwb_regwrite", {31'd0, bus.reg_write}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ir_m = '0;

    run_instr(K_ILL, 32'h0000007F, 0, 0, 1'b0, "ill_7f");

    for (int n = 0; n < 60; n++) begin
      k = kind_e'($urandom_range(0, 4));
      run_instr(k, gen(k), $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom),
                $sformatf("rnd%0d_k%0d", n, int'(k)));
    end
    cyc(P_FETCH, 1'b0, 1'b0, $urandom, "final_fetch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
